// File: rtl/noc_decoder_pkg.sv
// Shared types and width helpers for the leaf decoder.
package noc_decoder_pkg;

  typedef enum logic {
    ST_HEAD = 1'b0,
    ST_BODY = 1'b1
  } state_e;

  // Bit position of the tail marker within a flit.
  function automatic int unsigned tail_pos(input int unsigned w);
    return w - 1;
  endfunction

  // Select width: at least one bit even for two channels.
  function automatic int unsigned sel_width(input int unsigned n);
    if (n <= 2) return 1;
    return $unsigned($clog2(n));
  endfunction

endpackage

// File: rtl/decoder_leaf_n_sync_fifo.sv
// Per-channel synchronous FIFO; accepts a push while full when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_pop, do_push;

  assign valid_o = (wr_ptr_q != rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = valid_o && pop_i;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage carries no reset; pointers alone define occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/decoder_leaf_n.sv
// Packet decoder: routes each packet to the channel named by its head flit and reports the choice on S.
// Optional DECODER_LEAF_ERR_EN drops out-of-range packets and counts them on err_cnt_o.
module decoder_leaf_n
  import noc_decoder_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [W-1:0]                in_data_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic [N-1:0][W-1:0]         out_data_o,
  output logic [N-1:0]                out_valid_o,
  input  logic [N-1:0]                out_ready_i,
  output logic [sel_width(N)-1:0]     s_data_o,
  output logic                        s_valid_o,
  input  logic                        s_ready_i
`ifdef DECODER_LEAF_ERR_EN
  ,
  output logic [7:0]                  err_cnt_o
`endif
);

  localparam int unsigned SW = sel_width(N);
  localparam int unsigned TP = tail_pos(W);

  state_e        state_q, state_d;
  logic [1:0]    boot_q;
  logic [SW-1:0] sel_q, s_data_q;
  logic          s_valid_q;
  logic [SW-1:0] raw_sel_c, head_sel_c, cur_sel_c;
  logic          in_range_c, head_oor_c, drop_q;
  logic          full_sel_c, xfer_c, tail_c, push_c, s_free_c, s_load_c;
  logic [N-1:0]  full, push_vec;

  assign raw_sel_c  = in_data_i[SW-1:0];
  assign in_range_c = (32'(raw_sel_c) < N);
  assign tail_c     = in_data_i[TP];
  assign s_free_c   = !s_valid_q || s_ready_i;
  assign cur_sel_c  = (state_q == ST_HEAD) ? head_sel_c : sel_q;

`ifdef DECODER_LEAF_ERR_EN
  logic [7:0] err_cnt_q;
  logic       drop_head_c;

  assign head_sel_c  = raw_sel_c;
  assign head_oor_c  = !in_range_c;
  assign drop_head_c = xfer_c && (state_q == ST_HEAD) && head_oor_c;
  assign err_cnt_o   = err_cnt_q;

  // Drop flag follows the packet body; counter saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q    <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      if (xfer_c && (state_q == ST_HEAD)) drop_q <= head_oor_c;
      if (drop_head_c && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
`else
  assign head_sel_c = in_range_c ? raw_sel_c : SW'(N - 1);
  assign head_oor_c = 1'b0;
  assign drop_q     = 1'b0;
`endif

  always_comb begin
    full_sel_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cur_sel_c == SW'(i)) full_sel_c = full[i];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HEAD;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HEAD: if (xfer_c && !tail_c) state_d = ST_BODY;
      ST_BODY: if (xfer_c && tail_c)  state_d = ST_HEAD;
    endcase
  end

  // Handshake and routing outputs; input stays closed until the boot delay has elapsed.
  always_comb begin
    in_ready_o = 1'b0;
    xfer_c     = 1'b0;
    push_c     = 1'b0;
    s_load_c   = 1'b0;
    if (boot_q[1]) begin
      unique case (state_q)
        ST_HEAD: in_ready_o = head_oor_c || (!full_sel_c && s_free_c);
        ST_BODY: in_ready_o = drop_q || !full_sel_c;
      endcase
    end
    xfer_c = in_valid_i && in_ready_o;
    if (state_q == ST_HEAD) begin
      push_c   = xfer_c && !head_oor_c;
      s_load_c = xfer_c && !head_oor_c;
    end else begin
      push_c   = xfer_c && !drop_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_q    <= 2'b00;
      sel_q     <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
    end else begin
      boot_q <= {boot_q[0], 1'b1};
      if (xfer_c && (state_q == ST_HEAD)) sel_q <= head_sel_c;
      // S slot: a new head refills the slot even while it is being drained.
      if (s_load_c) begin
        s_valid_q <= 1'b1;
        s_data_q  <= head_sel_c;
      end else if (s_ready_i) begin
        s_valid_q <= 1'b0;
      end
    end
  end

  assign s_valid_o = s_valid_q;
  assign s_data_o  = s_data_q;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign push_vec[i] = push_c && (cur_sel_c == SW'(i));

    sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_vec[i]),
      .data_i  (in_data_i),
      .pop_i   (out_ready_i[i]),
      .full_o  (full[i]),
      .valid_o (out_valid_o[i]),
      .data_o  (out_data_o[i])
    );
  end

endmodule
